// File: rtl/alu_arbiter.sv
// ============================================================================
//  Module   : alu_arbiter
//  Purpose  : Two-requester arbiter that sequences operations onto one shared
//             combinational ALU (IDLE -> EXEC -> RESP), with a response per
//             requester.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module alu_arbiter #(
    parameter int RR_EN = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_req0_valid,
    input  logic [2:0] i_req0_op,
    input  logic [7:0] i_req0_a,
    input  logic [7:0] i_req0_b,
    input  logic       i_req1_valid,
    input  logic [2:0] i_req1_op,
    input  logic [7:0] i_req1_a,
    input  logic [7:0] i_req1_b,
    output logic       o_req0_ready,
    output logic       o_req1_ready,
    output logic       o_rsp0_valid,
    output logic [7:0] o_rsp0_data,
    output logic       o_rsp0_zero,
    output logic       o_rsp1_valid,
    output logic [7:0] o_rsp1_data,
    output logic       o_rsp1_zero,
    output logic [2:0] o_alu_op,
    output logic [7:0] o_alu_a,
    output logic [7:0] o_alu_b,
    input  logic [7:0] i_alu_out,
    input  logic       i_alu_zero,
    output logic       o_busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0] r_state;
    logic [2:0] r_op;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic       r_winner;
    logic       r_last;
    logic [7:0] r_rsp0_data;
    logic       r_rsp0_zero;
    logic [7:0] r_rsp1_data;
    logic       r_rsp1_zero;

    logic       w_grant1;
    logic       w_idle;
    logic       w_accept;

    // Contention resolves to the requester not served last (round-robin) or to requester 0.
    always_comb begin
        w_grant1 = i_req1_valid;
        if (i_req0_valid && i_req1_valid) begin
            w_grant1 = (RR_EN != 0) ? ~r_last : 1'b0;
        end
    end

    assign w_idle       = (r_state == S_IDLE) && !rst;
    assign o_req0_ready = w_idle && i_req0_valid && !w_grant1;
    assign o_req1_ready = w_idle && i_req1_valid &&  w_grant1;
    assign w_accept     = o_req0_ready || o_req1_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_op        <= 3'd0;
            r_a         <= 8'd0;
            r_b         <= 8'd0;
            r_winner    <= 1'b0;
            r_last      <= 1'b1;
            r_rsp0_data <= 8'd0;
            r_rsp0_zero <= 1'b0;
            r_rsp1_data <= 8'd0;
            r_rsp1_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op     <= w_grant1 ? i_req1_op : i_req0_op;
                        r_a      <= w_grant1 ? i_req1_a  : i_req0_a;
                        r_b      <= w_grant1 ? i_req1_b  : i_req0_b;
                        r_winner <= w_grant1;
                        r_last   <= w_grant1;
                        r_state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // Results land in per-requester registers so each response holds its last value.
                    if (r_winner) begin
                        r_rsp1_data <= i_alu_out;
                        r_rsp1_zero <= i_alu_zero;
                    end else begin
                        r_rsp0_data <= i_alu_out;
                        r_rsp0_zero <= i_alu_zero;
                    end
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_rsp0_valid = (r_state == S_RESP) && !r_winner && !rst;
    assign o_rsp1_valid = (r_state == S_RESP) &&  r_winner && !rst;
    assign o_rsp0_data  = r_rsp0_data;
    assign o_rsp0_zero  = r_rsp0_zero;
    assign o_rsp1_data  = r_rsp1_data;
    assign o_rsp1_zero  = r_rsp1_zero;
    assign o_alu_op     = r_op;
    assign o_alu_a      = r_a;
    assign o_alu_b      = r_b;
    assign o_busy       = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
//  Module   : tb_alu_arbiter
//  Purpose  : Self-checking bench for alu_arbiter with a behavioural shared ALU.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_arbiter;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_XOR = 3'd2;
    localparam logic [2:0] OP_SHL = 3'd3;
    localparam logic [2:0] OP_SHR = 3'd4;
    localparam logic [2:0] OP_AND = 3'd5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       v0, v1;
    logic [2:0] op0, op1;
    logic [7:0] a0, b0, a1, b1;
    logic       rdy0, rdy1, rv0, rv1, rz0, rz1, busy, alu_zero;
    logic [7:0] rd0, rd1, alu_a, alu_b, alu_out;
    logic [2:0] alu_op;

    logic       fv0, fv1, frdy0, frdy1, frv0, frv1, frz0, frz1, fbusy, falu_zero;
    logic [7:0] frd0, frd1, falu_a, falu_b, falu_out;
    logic [2:0] falu_op;

    int checks = 0;
    int errors = 0;

    function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_XOR:  return a ^ b;
            OP_SHL:  return a << b[2:0];
            OP_SHR:  return a >> b[2:0];
            OP_AND:  return a & b;
            3'd6:    return a | b;
            default: return a;
        endcase
    endfunction

    assign alu_out   = alu_f(alu_op, alu_a, alu_b);
    assign alu_zero  = (alu_a == alu_b);
    assign falu_out  = alu_f(falu_op, falu_a, falu_b);
    assign falu_zero = (falu_a == falu_b);

    alu_arbiter #(.RR_EN(1)) dut (
        .clk(clk), .rst(rst),
        .i_req0_valid(v0), .i_req0_op(op0), .i_req0_a(a0), .i_req0_b(b0),
        .i_req1_valid(v1), .i_req1_op(op1), .i_req1_a(a1), .i_req1_b(b1),
        .o_req0_ready(rdy0), .o_req1_ready(rdy1),
        .o_rsp0_valid(rv0), .o_rsp0_data(rd0), .o_rsp0_zero(rz0),
        .o_rsp1_valid(rv1), .o_rsp1_data(rd1), .o_rsp1_zero(rz1),
        .o_alu_op(alu_op), .o_alu_a(alu_a), .o_alu_b(alu_b),
        .i_alu_out(alu_out), .i_alu_zero(alu_zero), .o_busy(busy)
    );

    alu_arbiter #(.RR_EN(0)) dut_fp (
        .clk(clk), .rst(rst),
        .i_req0_valid(fv0), .i_req0_op(OP_ADD), .i_req0_a(8'h01), .i_req0_b(8'h02),
        .i_req1_valid(fv1), .i_req1_op(OP_SUB), .i_req1_a(8'h09), .i_req1_b(8'h04),
        .o_req0_ready(frdy0), .o_req1_ready(frdy1),
        .o_rsp0_valid(frv0), .o_rsp0_data(frd0), .o_rsp0_zero(frz0),
        .o_rsp1_valid(frv1), .o_rsp1_data(frd1), .o_rsp1_zero(frz1),
        .o_alu_op(falu_op), .o_alu_a(falu_a), .o_alu_b(falu_b),
        .i_alu_out(falu_out), .i_alu_zero(falu_zero), .o_busy(fbusy)
    );

    typedef struct {
        logic       id;
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_d;
        logic       exp_z;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input logic id, input logic v, input logic [2:0] op,
                           input logic [7:0] a, input logic [7:0] b);
        if (id) begin v1 = v; op1 = op; a1 = a; b1 = b; end
        else    begin v0 = v; op0 = op; a0 = a; b0 = b; end
    endtask

    function automatic logic rdy_of(input logic id);
        return id ? rdy1 : rdy0;
    endfunction

    function automatic logic rv_of(input logic id);
        return id ? rv1 : rv0;
    endfunction

    // Single requester op: wait for READY, accept, then check EXEC, RESP and hold.
    task automatic run_op(input vec_t t, input int k);
        int n;
        set_req(t.id, 1'b1, t.op, t.a, t.b);
        #1;
        n = 0;
        while (!rdy_of(t.id) && n < 10) begin
            @(negedge clk); #1; n++;
        end
        chk($sformatf("v%0d_ready_timeout", k), 32'(n < 10), 1);
        chk($sformatf("v%0d_other_ready", k), 32'(rdy_of(!t.id)), 0);
        @(posedge clk); #1;
        set_req(t.id, 1'b0, 3'd0, 8'd0, 8'd0);
        @(negedge clk);
        chk($sformatf("v%0d_exec_busy", k), 32'(busy), 1);
        chk($sformatf("v%0d_exec_alu", k), {13'd0, alu_op, alu_a, alu_b}, {13'd0, t.op, t.a, t.b});
        chk($sformatf("v%0d_exec_rsp", k), 32'({rv1, rv0}), 0);
        @(negedge clk);
        chk($sformatf("v%0d_rsp_valid", k), 32'({rv_of(t.id), rv_of(!t.id)}), 32'b10);
        chk($sformatf("v%0d_rsp_data", k), 32'(t.id ? rd1 : rd0), 32'(t.exp_d));
        chk($sformatf("v%0d_rsp_zero", k), 32'(t.id ? rz1 : rz0), 32'(t.exp_z));
        @(negedge clk);
        chk($sformatf("v%0d_idle", k), 32'({busy, rv1, rv0}), 0);
        chk($sformatf("v%0d_hold", k), 32'(t.id ? {rz1, rd1} : {rz0, rd0}), 32'({t.exp_z, t.exp_d}));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, n, bad, c0, c1;
        logic [7:0] d0, d1;
        logic drop0, drop1;

        vecs[0] = '{1'b0, OP_ADD, 8'h12, 8'h34, 8'h46, 1'b0};
        vecs[1] = '{1'b1, OP_SUB, 8'h05, 8'h05, 8'h00, 1'b1};
        vecs[2] = '{1'b0, OP_XOR, 8'hF0, 8'h3C, 8'hCC, 1'b0};
        vecs[3] = '{1'b1, OP_SHL, 8'h01, 8'h03, 8'h08, 1'b0};
        vecs[4] = '{1'b0, OP_SHR, 8'h80, 8'h04, 8'h08, 1'b0};
        vecs[5] = '{1'b1, OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b0};
        vecs[6] = '{1'b0, OP_SUB, 8'h03, 8'h05, 8'hFE, 1'b0};
        vecs[7] = '{1'b1, OP_AND, 8'h5A, 8'h5A, 8'h5A, 1'b1};

        rst = 1'b1; fv0 = 1'b0; fv1 = 1'b0;
        set_req(1'b0, 1'b1, OP_ADD, 8'h11, 8'h22);
        set_req(1'b1, 1'b1, OP_SUB, 8'h33, 8'h44);
        repeat (2) @(negedge clk);
        #1;
        chk("reset_ready", 32'({rdy1, rdy0}), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_alu", {13'd0, alu_op, alu_a, alu_b}, 0);
        chk("reset_rsp", {14'd0, rv1, rv0, rd1, rd0}, 0);
        set_req(1'b0, 1'b0, 3'd0, 8'd0, 8'd0);
        set_req(1'b1, 1'b0, 3'd0, 8'd0, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_idle", 32'({busy, rv1, rv0}), 0);

        for (int i = 0; i < 8; i++) run_op(vecs[i], i);

        // Contested start from reset: requester 0 first, then requester 1.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        set_req(1'b0, 1'b1, OP_SHL, 8'h01, 8'h03);
        set_req(1'b1, 1'b1, OP_SHR, 8'h80, 8'h04);
        #1;
        chk("rr_first_grant", 32'({rdy1, rdy0}), 32'b01);
        t0 = -1; t1 = -1; d0 = 8'd0; d1 = 8'd0;
        for (int i = 0; i < 12; i++) begin
            drop0 = rdy0; drop1 = rdy1;
            if (rv0) begin t0 = i; d0 = rd0; end
            if (rv1) begin t1 = i; d1 = rd1; end
            @(posedge clk); #1;
            if (drop0) set_req(1'b0, 1'b0, 3'd0, 8'd0, 8'd0);
            if (drop1) set_req(1'b1, 1'b0, 3'd0, 8'd0, 8'd0);
            @(negedge clk); #1;
        end
        chk("rr_rsp0_latency", 32'(t0), 2);
        chk("rr_rsp_spacing", 32'(t1 - t0), 3);
        chk("rr_rsp0_data", 32'(d0), 32'h08);
        chk("rr_rsp1_data", 32'(d1), 32'h08);

        // Reset during EXEC aborts the operation.
        set_req(1'b0, 1'b1, OP_ADD, 8'hFF, 8'h01);
        #1;
        chk("abort_ready", 32'(rdy0), 1);
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, 3'd0, 8'd0, 8'd0);
        @(negedge clk);
        chk("abort_exec_busy", 32'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_no_rsp", 32'({rv1, rv0}), 0);
        chk("abort_busy_alu", {23'd0, busy, alu_a}, 0);
        chk("abort_rsp_clear", 32'(rd0), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_after", 32'({busy, rv1, rv0}), 0);

        // Requester 0 waits while busy with requester 1's op.
        set_req(1'b1, 1'b1, OP_SUB, 8'h09, 8'h02);
        #1;
        chk("busy_req1_ready", 32'(rdy1), 1);
        @(posedge clk); #1;
        set_req(1'b1, 1'b0, 3'd0, 8'd0, 8'd0);
        set_req(1'b0, 1'b1, OP_XOR, 8'hF0, 8'h3C);
        #1;
        n = 0; bad = 0;
        if (rdy0) bad++;
        while (!rdy0 && n < 10) begin
            @(negedge clk); #1; n++;
            if (busy && rdy0) bad++;
        end
        chk("busy_ready_low", 32'(bad), 0);
        chk("busy_wait_cycles", 32'(n), 3);
        chk("busy_req1_result", 32'(rd1), 32'h07);
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, 3'd0, 8'd0, 8'd0);
        @(negedge clk); @(negedge clk);
        chk("busy_xor_rsp", 32'({rv0, rd0}), 32'h1CC);

        // Fixed priority: both valid for 9 cycles.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; fv0 = 1'b1; fv1 = 1'b1;
        c0 = 0; c1 = 0;
        for (int i = 0; i < 9; i++) begin
            #1;
            if (frdy0) c0++;
            if (frdy1) c1++;
            @(negedge clk);
        end
        fv0 = 1'b0; fv1 = 1'b0;
        chk("fp_req0_grants", 32'(c0), 3);
        chk("fp_req1_grants", 32'(c1), 0);
        chk("fp_rsp0_data", 32'(frd0), 32'h03);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
